// File: rtl/unpang_shift_pipe5_if.sv
// Stream bundle for unpang_shift_pipe5: compacted pang beat in, restored lanes plus lane mask out.
interface unpang_shift_pipe5_if #(
    parameter int SUB_BLK_BIT = 8,
    parameter int SFT_BIT     = 4
);
    localparam int LANES = 1 << SFT_BIT;

    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*SUB_BLK_BIT-1:0] pang_in;
    logic [SFT_BIT-1:0]           sft_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES*SUB_BLK_BIT-1:0] d_out;
    logic [LANES-1:0]             lane_mask;

    modport master (
        output in_valid, pang_in, sft_in, out_ready,
        input  in_ready, out_valid, d_out, lane_mask
    );

    modport slave (
        input  in_valid, pang_in, sft_in, out_ready,
        output in_ready, out_valid, d_out, lane_mask
    );
endinterface

// File: rtl/unpang_shift_pipe5.sv
// 5-stage pipelined lane un-shifter restoring pang sub-blocks to their original positions.
// Optional UNPANG_ROTATE_EN: rotate lanes instead of zero-filling (lane_mask then all ones).
module unpang_shift_pipe5 #(
    parameter int SUB_BLK_BIT = 8,
    parameter int SFT_BIT     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    unpang_shift_pipe5_if.slave    bus
);
    localparam int LANES = 1 << SFT_BIT;
    localparam int DW    = LANES * SUB_BLK_BIT;

    logic [DW-1:0]      data_q [0:4];
    logic [LANES-1:0]   mask_q [0:4];
    logic [SFT_BIT-1:0] sft_q  [0:3];
    logic               vld_q  [0:4];
    logic               adv;

    function automatic logic [DW-1:0] shift_data(input logic [DW-1:0] d, input int k);
`ifdef UNPANG_ROTATE_EN
        return (d << (k * SUB_BLK_BIT)) | (d >> (DW - k * SUB_BLK_BIT));
`else
        return d << (k * SUB_BLK_BIT);
`endif
    endfunction

    function automatic logic [LANES-1:0] shift_mask(input logic [LANES-1:0] m, input int k);
`ifdef UNPANG_ROTATE_EN
        return (m << k) | (m >> (LANES - k));
`else
        return m << k;
`endif
    endfunction

    assign adv          = bus.out_ready | ~vld_q[4];
    assign bus.in_ready = adv;

    // Bubbles enter as all-zero data/mask so outputs read zero until the first real beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < 5; n++) begin
                data_q[n] <= '0;
                mask_q[n] <= '0;
                vld_q[n]  <= 1'b0;
            end
            for (int n = 0; n < 4; n++) begin
                sft_q[n] <= '0;
            end
        end else if (adv) begin
            vld_q[0]  <= bus.in_valid;
            data_q[0] <= bus.in_valid ? bus.pang_in : '0;
            sft_q[0]  <= bus.in_valid ? bus.sft_in : '0;
            mask_q[0] <= {LANES{bus.in_valid}};
            for (int n = 1; n < 5; n++) begin
                vld_q[n]  <= vld_q[n-1];
                data_q[n] <= sft_q[n-1][n-1] ? shift_data(data_q[n-1], 1 << (n-1)) : data_q[n-1];
                mask_q[n] <= sft_q[n-1][n-1] ? shift_mask(mask_q[n-1], 1 << (n-1)) : mask_q[n-1];
            end
            for (int n = 1; n < 4; n++) begin
                sft_q[n] <= sft_q[n-1];
            end
        end
    end

    assign bus.out_valid = vld_q[4];
    assign bus.d_out     = data_q[4];
    assign bus.lane_mask = mask_q[4];
endmodule

// File: doc/unpang_shift_pipe5.md
Name: unpang_shift_pipe5

Overview:
- Inverse of the pang distribution mux: takes 16 compacted pang sub-blocks plus the shift amount that produced them, and restores original lane positions.
- Output lane k = pang lane (k - sft). Lanes below sft are zero-filled.
- 5-stage pipelined barrel shifter: input register, then shift-by-1/2/4/8 stages. Carries a valid/ready handshake with global stall.
- Sits on the return path of the ping-pong datapath, before sub-block write-back.

Parameters:
- SUB_BLK_BIT, 8, width of one sub-block lane.
- SFT_BIT, 4, shift-amount width. Lane count is fixed at 16 = 2^SFT_BIT.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- pang_in  input  16*SUB_BLK_BIT  lane j at bits [j*SUB_BLK_BIT +: SUB_BLK_BIT].
- sft_in  input  SFT_BIT  shift amount associated with the beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts output.
- d_out  output  16*SUB_BLK_BIT  restored lanes, same packing as pang_in.
- lane_mask  output  16  bit k=1 when d_out lane k carries real data (k >= sft).

Behaviour:
- Reset (reset=0, async): all stage valid bits, data registers, sft registers and mask registers clear to 0. Outputs: out_valid=0, d_out=0, lane_mask=0. in_ready=1 after reset.
- Advance enable: adv = out_ready | ~out_valid.
  - When adv=1, every stage shifts forward one position.
  - When adv=0, every stage holds its contents.
  - in_ready = adv (combinational).
- Stage 1: on adv, captures pang_in, sft_in, in_valid. A beat transfers only when in_valid & in_ready.
- Stages 2..5: stage n applies a shift of 2^(n-2) lanes toward higher index when the carried sft bit (n-2) is 1.
  - Vacated low lanes become zero.
  - The carried mask is shifted the same way, starting from all-ones at stage 1.
- Stage 5 registers drive d_out, lane_mask and out_valid directly. No combinational path from input to output.
- Latency: 5 cycles from accepted beat to out_valid when never stalled. Throughput: 1 beat/cycle.
- Bubbles (valid=0) are stored and propagated like data. The data contents of bubble stages are don't-care, except that d_out and lane_mask read 0 until the first valid beat.
- sft=0: pass-through, lane_mask=16'hFFFF.
- sft=15: only lane 15 = pang lane 0, lane_mask=16'h8000.
- Stall with full pipe: all 5 beats held intact; no beat dropped or duplicated. Output is stable while out_valid & ~out_ready.
- Simultaneous in_valid and stall: in_ready=0, so the beat is not accepted; the upstream source must hold it.
- Reset asserted mid-operation: all in-flight beats are discarded immediately. out_valid drops asynchronously.

Optional Feature:
- Macro: UNPANG_ROTATE_EN.
- Defined: stages rotate instead of zero-filling. Output lane k = pang lane ((k - sft) mod 16), and lane_mask is forced to 16'hFFFF.
- Undefined: zero-fill and computed lane_mask as above.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset, then 8 idle cycles: out_valid=0, d_out=0, lane_mask=0, in_ready=1.
- pang_in lane j = j+1 (0x01..0x10), sft=3, out_ready=1: 5 cycles later out_valid=1; lanes 0..2 = 0; lane 3 = 0x01, lane 15 = 0x0D; lane_mask=16'hFFF8.
- Back-to-back beats with sft = 0, 1, 15, 8: outputs appear on consecutive cycles in order.
  - sft=0: identity.
  - sft=15: lane15 = 0x01, mask 16'h8000.
  - sft=8: mask 16'hFF00.
- Fill the pipe, hold out_ready=0 for 10 cycles: in_ready=0 throughout and d_out is stable. Then release: 5 beats drain in order with no loss.
- Assert reset in the cycle after out_valid rises: out_valid=0 immediately. After release, no stale beat emerges.
- UNPANG_ROTATE_EN build, sft=3, lanes 0x01..0x10: lanes 0..2 = 0x0E, 0x0F, 0x10; lane 3 = 0x01; mask 16'hFFFF.
